// File: rtl/biu_pkg.sv
// Shared bus-interface types and constants for the prefetch path.
// Used by bus_interface, execution and the prefetch queue.
package biu_pkg;

    localparam int          QUEUE_DEPTH = 4;
    localparam int          QPTR_W      = 2;
    localparam logic [15:0] RESET_IP_C  = 16'h0000;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    // Outstanding-discard counter is only 2 bits wide, so clamp to 0..3.
    function automatic logic [1:0] sat_discard(input int v);
        if (v <= 0)
            return 2'd0;
        else if (v >= 3)
            return 2'd3;
        else
            return 2'(v);
    endfunction

endpackage

// File: rtl/prefetch_ram.sv
// Prefetch byte storage: one synchronous write port, asynchronous read.
// Contents are not reset; the queue pointers decide what is valid.
module prefetch_ram
    import biu_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int PTR_W = QPTR_W
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  byte_t            wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output byte_t            rdata_o
);

    byte_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch FIFO with fetch/exec IP bookkeeping and slot
// reservation for in-flight BIU code fetches.
module prefetch_queue
    import biu_pkg::*;
#(
    parameter int          DEPTH    = QUEUE_DEPTH,
    parameter int          PTR_W    = QPTR_W,
    parameter logic [15:0] RESET_IP = RESET_IP_C
) (
    input  logic        CLKx4,
    input  logic        RESET,
    input  logic        fetchStart,
    input  logic        pushValid,
    input  logic [7:0]  pushData,
    input  logic        advanceTop,
    input  logic        flush,
    input  logic [15:0] flushIP,
    input  logic        suspend,
    output logic [7:0]  prefetchTop,
    output logic        prefetchEmpty,
    output logic        prefetchFull,
    output logic        fetchAllowed,
    output logic [15:0] fetchIP,
    output logic [15:0] execIP,
    output logic        discardPending
);

    localparam int              CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]  OCC_LIMIT = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] resv_q,   resv_d;
    logic [1:0]       discard_q, discard_d;
    word_t            fetch_ip_q, fetch_ip_d;

    logic [CNT_W:0]   occupancy;
    logic             push_acc;
    logic             fetch_go;
    logic             adv_go;

    // Occupancy counts both stored bytes and slots promised to in-flight fetches.
    assign occupancy    = {1'b0, count_q} + {1'b0, resv_q};
    assign fetchAllowed = !suspend && !flush && (occupancy < OCC_LIMIT);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        resv_d     = resv_q;
        discard_d  = discard_q;
        fetch_ip_d = fetch_ip_q;
        push_acc   = 1'b0;
        fetch_go   = 1'b0;
        adv_go     = 1'b0;

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            resv_d     = '0;
            fetch_ip_d = flushIP;
            // Every reserved fetch becomes a byte to drop; a push this clock is one of them.
            discard_d  = sat_discard(int'(discard_q) + int'(resv_q) - (pushValid ? 1 : 0));
        end else begin
            if (pushValid) begin
                if (discard_q != 2'd0)
                    discard_d = discard_q - 2'd1;
                else if (resv_q != '0)
                    push_acc = 1'b1;
            end
            fetch_go = fetchStart && fetchAllowed;
            adv_go   = advanceTop && (count_q != '0);

            if (push_acc)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (adv_go)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, push_acc} - {{PTR_W{1'b0}}, adv_go};
            resv_d  = resv_q  + {{PTR_W{1'b0}}, fetch_go} - {{PTR_W{1'b0}}, push_acc};
            if (fetch_go)
                fetch_ip_d = fetch_ip_q + 16'd1;
        end
    end

    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            resv_q     <= '0;
            discard_q  <= 2'd0;
            fetch_ip_q <= RESET_IP;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            resv_q     <= resv_d;
            discard_q  <= discard_d;
            fetch_ip_q <= fetch_ip_d;
        end
    end

    prefetch_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_i   (CLKx4),
        .we_i    (push_acc && !RESET),
        .waddr_i (wr_ptr_q),
        .wdata_i (pushData),
        .raddr_i (rd_ptr_q),
        .rdata_o (prefetchTop)
    );

    assign prefetchEmpty  = (count_q == '0);
    assign prefetchFull   = (count_q == CNT_FULL);
    assign fetchIP        = fetch_ip_q;
    assign execIP         = fetch_ip_q - 16'(count_q) - 16'(resv_q);
    assign discardPending = (discard_q != 2'd0);

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomised and directed bench for prefetch_queue, checked against a
// queue-based reference model through a per-cycle scoreboard.
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0, pv = 1'b0, adv = 1'b0, fl = 1'b0, sus = 1'b0;
    logic [7:0]  pd = 8'h00;
    logic [15:0] fip = 16'h0000;

    logic [7:0]  top;
    logic        empty, full, allowed, dpend;
    logic [15:0] fetch_ip, exec_ip;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prefetch_queue dut (
        .CLKx4          (clk),
        .RESET          (rst),
        .fetchStart     (fs),
        .pushValid      (pv),
        .pushData       (pd),
        .advanceTop     (adv),
        .flush          (fl),
        .flushIP        (fip),
        .suspend        (sus),
        .prefetchTop    (top),
        .prefetchEmpty  (empty),
        .prefetchFull   (full),
        .fetchAllowed   (allowed),
        .fetchIP        (fetch_ip),
        .execIP         (exec_ip),
        .discardPending (dpend)
    );

    // Reference model: contents as a plain byte queue plus counters.
    logic [7:0] m_q[$];
    int         m_resv = 0;
    int         m_disc = 0;
    int         m_ip   = 0;
    bit         m_valid = 0;

    typedef struct {
        logic        empty, full, allowed, dpend, top_vld;
        logic [15:0] fip, eip;
        logic [7:0]  top;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]  s_top;
    logic        s_empty, s_full, s_allowed, s_dpend;
    logic [15:0] s_fip, s_eip;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void model_step();
        int  d;
        bit  adv_ok;
        if (rst) begin
            m_q.delete();
            m_resv = 0; m_disc = 0; m_ip = 0;
            m_valid = 1;
        end else if (!m_valid) begin
            return;
        end else if (fl) begin
            d = m_disc + m_resv - (pv ? 1 : 0);
            m_disc = (d < 0) ? 0 : (d > 3) ? 3 : d;
            m_q.delete();
            m_resv = 0;
            m_ip = int'(fip);
        end else begin
            bit ok_fetch;
            ok_fetch = !sus && (m_q.size() + m_resv < 4);
            adv_ok = m_q.size() > 0;
            if (pv) begin
                if (m_disc > 0) m_disc--;
                else if (m_resv > 0) begin m_q.push_back(pd); m_resv--; end
            end
            if (adv && adv_ok) void'(m_q.pop_front());
            if (fs && ok_fetch) begin m_resv++; m_ip = (m_ip + 1) % 65536; end
        end
    endfunction

    task automatic cyc(input logic i_fs, input logic i_pv, input logic [7:0] i_pd,
                       input logic i_adv, input logic i_fl, input logic [15:0] i_fip,
                       input logic i_sus, input logic i_rst);
        exp_t e;
        fs = i_fs; pv = i_pv; pd = i_pd; adv = i_adv;
        fl = i_fl; fip = i_fip; sus = i_sus; rst = i_rst;
        if (m_valid && !rst) begin
            e.empty   = (m_q.size() == 0);
            e.full    = (m_q.size() == 4);
            e.allowed = !i_sus && !i_fl && (m_q.size() + m_resv < 4);
            e.dpend   = (m_disc > 0);
            e.fip     = 16'(m_ip);
            e.eip     = 16'(m_ip - m_q.size() - m_resv);
            e.top_vld = (m_q.size() > 0);
            e.top     = e.top_vld ? m_q[0] : 8'h00;
            exp_q.push_back(e);
        end
        #2;
        s_top = top; s_empty = empty; s_full = full; s_allowed = allowed;
        s_dpend = dpend; s_fip = fetch_ip; s_eip = exec_ip;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle();                        cyc(0,0,8'h00,0,0,16'h0,0,0); endtask
    task automatic fetch();                       cyc(1,0,8'h00,0,0,16'h0,0,0); endtask
    task automatic push(input logic [7:0] d);     cyc(0,1,d,    0,0,16'h0,0,0); endtask
    task automatic advance();                     cyc(0,0,8'h00,1,0,16'h0,0,0); endtask
    task automatic do_flush(input logic [15:0] a); cyc(0,0,8'h00,0,1,a,   0,0); endtask

    // Monitor: every sampled cycle is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("empty",   32'(empty),   32'(e.empty));
                chk("full",    32'(full),    32'(e.full));
                chk("allowed", 32'(allowed), 32'(e.allowed));
                chk("dpend",   32'(dpend),   32'(e.dpend));
                chk("fetchIP", 32'(fetch_ip), 32'(e.fip));
                chk("execIP",  32'(exec_ip),  32'(e.eip));
                if (e.top_vld) chk("top", 32'(top), 32'(e.top));
            end
        end
    end

    initial begin
        #1;
        cyc(0,0,8'h00,0,0,16'h0,0,1);
        idle();
        chk("rst_empty",   32'(s_empty),   32'd1);
        chk("rst_full",    32'(s_full),    32'd0);
        chk("rst_dpend",   32'(s_dpend),   32'd0);
        chk("rst_execIP",  32'(s_eip),     32'h0000);
        chk("rst_allowed", 32'(s_allowed), 32'd1);

        for (int i = 0; i < 4; i++) begin
            fetch();
            push(8'h90 + 8'(i));
        end
        idle();
        chk("fill_full",    32'(s_full),    32'd1);
        chk("fill_allowed", 32'(s_allowed), 32'd0);
        chk("fill_fetchIP", 32'(s_fip),     32'h0004);
        chk("fill_execIP",  32'(s_eip),     32'h0000);
        chk("fill_top",     32'(s_top),     32'h90);

        for (int i = 1; i < 4; i++) begin
            advance();
            idle();
            chk("drain_top", 32'(s_top), 32'(8'h90 + 8'(i)));
        end
        advance();
        idle();
        chk("drain_empty",  32'(s_empty), 32'd1);
        chk("drain_execIP", 32'(s_eip),   32'h0004);

        fetch(); fetch();
        do_flush(16'h1234);
        push(8'hAA);
        idle();
        chk("flush_dpend1", 32'(s_dpend), 32'd1);
        push(8'hBB);
        idle();
        chk("flush_dpend0",  32'(s_dpend), 32'd0);
        chk("flush_empty",   32'(s_empty), 32'd1);
        chk("flush_fetchIP", 32'(s_fip),   32'h1234);

        do_flush(16'hFFFF);
        fetch();
        push(8'hCC);
        idle();
        chk("wrap_fetchIP", 32'(s_fip), 32'h0000);
        chk("wrap_execIP",  32'(s_eip), 32'hFFFF);
        chk("wrap_top",     32'(s_top), 32'hCC);

        do_flush(16'h0000);
        for (int i = 0; i < 4; i++) fetch();
        push(8'h01); push(8'h02); push(8'h03);
        cyc(0,1,8'h55,1,0,16'h0,0,0);
        idle();
        chk("pa_allowed", 32'(s_allowed), 32'd1);
        chk("pa_execIP",  32'(s_eip),     32'h0001);
        advance(); advance();
        idle();
        chk("pa_tail", 32'(s_top), 32'h55);

        advance();
        cyc(1,0,8'h00,0,0,16'h0,1,0);
        chk("sus_allowed", 32'(s_allowed), 32'd0);
        idle();
        chk("sus_fetchIP", 32'(s_fip), 32'h0004);
        fetch();
        cyc(0,0,8'h00,0,0,16'h0,0,1);
        idle();
        chk("rst2_empty",   32'(s_empty),   32'd1);
        chk("rst2_fetchIP", 32'(s_fip),     32'h0000);
        chk("rst2_execIP",  32'(s_eip),     32'h0000);
        chk("rst2_allowed", 32'(s_allowed), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            logic r_fs, r_pv, r_adv, r_fl, r_sus, r_rst;
            r_rst = ($urandom_range(0, 299) == 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_sus = ($urandom_range(0, 7) == 0);
            r_fs  = ($urandom_range(0, 1) == 1);
            r_adv = ($urandom_range(0, 2) == 0);
            r_pv  = (m_resv + m_disc > 0) && ($urandom_range(0, 1) == 1);
            cyc(r_fs, r_pv, 8'($urandom), r_adv, r_fl, 16'($urandom), r_sus, r_rst);
        end
        idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
